// File: rtl/tmu2_fifo.sv
// tmu2_fifo: stb/ack pipeline buffer, 2^depth-word RAM plus a registered output stage.
// Optional max_level watermark output when TMU2_FIFO_WATERMARK_EN is defined.
module tmu2_fifo #(
   parameter int width        = 8,
   parameter int depth        = 2,
   parameter int afull_margin = 1
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             flush,
   output logic             busy,
   output logic [depth:0]   level,
   output logic             almost_full,
   input  logic             pipe_stb_i,
   output logic             pipe_ack_o,
   input  logic [width-1:0] dat_i,
   output logic             pipe_stb_o,
   input  logic             pipe_ack_i,
   output logic [width-1:0] dat_o
`ifdef TMU2_FIFO_WATERMARK_EN
   ,
   output logic [depth:0]   max_level
`endif
);

   localparam int RAM_WORDS = 1 << depth;
   localparam int CAP       = RAM_WORDS + 1;
   localparam logic [depth:0] RAM_FULL = (depth+1)'(RAM_WORDS);
   localparam logic [depth:0] AF_TH    = (depth+1)'(CAP - afull_margin);

   logic [width-1:0] storage [RAM_WORDS];
   logic [depth-1:0] produce;
   logic [depth-1:0] consume;
   logic [depth:0]   ram_count;
   logic             out_valid;
   logic             inc;
   logic             dec;
   logic             load;
   logic [depth:0]   level_nxt;

   assign pipe_ack_o  = (ram_count != RAM_FULL) & ~flush;
   assign pipe_stb_o  = out_valid;
   assign inc         = pipe_stb_i & pipe_ack_o;
   assign dec         = out_valid & pipe_ack_i;
   // flush suppresses the load so the output stage empties at the flush edge
   assign load        = (ram_count != '0) & (~out_valid | pipe_ack_i) & ~flush;
   assign busy        = (level != '0);
   assign almost_full = (level >= AF_TH);

   always_comb begin
      level_nxt = level;
      if (flush)
         level_nxt = '0;
      else if (inc & ~dec)
         level_nxt = level + 1'b1;
      else if (dec & ~inc)
         level_nxt = level - 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (inc)
         storage[produce] <= dat_i;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         produce   <= '0;
         consume   <= '0;
         ram_count <= '0;
         out_valid <= 1'b0;
         level     <= '0;
         dat_o     <= '0;
      end else begin
         level <= level_nxt;
         if (flush) begin
            produce   <= '0;
            consume   <= '0;
            ram_count <= '0;
            out_valid <= 1'b0;
         end else begin
            if (inc)
               produce <= produce + 1'b1;
            if (load) begin
               dat_o     <= storage[consume];
               consume   <= consume + 1'b1;
               out_valid <= 1'b1;
            end else if (dec) begin
               out_valid <= 1'b0;
            end
            if (inc & ~load)
               ram_count <= ram_count + 1'b1;
            else if (load & ~inc)
               ram_count <= ram_count - 1'b1;
         end
      end
   end

`ifdef TMU2_FIFO_WATERMARK_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         max_level <= '0;
      else if (flush)
         max_level <= '0;
      else if (level_nxt > max_level)
         max_level <= level_nxt;
   end
`endif

endmodule
